// File: rtl/llc_port_arbiter.sv
// -----------------------------------------------------------------------------
// llc_port_arbiter
//
// Shares the single last-level-cache slave port between the L1-I miss path
// and the L1-D miss / write-back paths. Exactly one LLC transaction is in
// flight at a time. Returned lines are routed back to the requester that
// issued the read. Reads cannot be starved by long write-back bursts.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   I_R_ADDR/_VALID            L1-I line read request (held until data)
//   I_R_DATA/_VALID            L1-I read line, valid is a 1-cycle pulse
//   D_R_ADDR/_VALID            L1-D line read request (held until data)
//   D_R_DATA/_VALID            L1-D read line, valid is a 1-cycle pulse
//   D_W_VALID/_ADDR/_DATA      L1-D write-back request
//   D_W_READY                  write-back accepted this cycle
//   D_W_COMPLETE               write-back committed in LLC (1-cycle pulse)
//   M_R_ADDR/_VALID            LLC read request, line aligned
//   M_R_DATA/_VALID            LLC read response
//   M_W_VALID/_ADDR/_DATA      LLC write request
//   M_W_READY, M_W_COMPLETE    LLC write accept / commit pulse
// -----------------------------------------------------------------------------
module llc_port_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int LINE_WIDTH   = 512,
  parameter int WR_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] I_R_ADDR,
  input  logic                  I_R_ADDR_VALID,
  output logic [LINE_WIDTH-1:0] I_R_DATA,
  output logic                  I_R_DATA_VALID,
  input  logic [ADDR_WIDTH-1:0] D_R_ADDR,
  input  logic                  D_R_ADDR_VALID,
  output logic [LINE_WIDTH-1:0] D_R_DATA,
  output logic                  D_R_DATA_VALID,
  input  logic                  D_W_VALID,
  input  logic [ADDR_WIDTH-1:0] D_W_ADDR,
  input  logic [LINE_WIDTH-1:0] D_W_DATA,
  output logic                  D_W_READY,
  output logic                  D_W_COMPLETE,
  output logic [ADDR_WIDTH-1:0] M_R_ADDR,
  output logic                  M_R_ADDR_VALID,
  input  logic [LINE_WIDTH-1:0] M_R_DATA,
  input  logic                  M_R_DATA_VALID,
  output logic                  M_W_VALID,
  output logic [ADDR_WIDTH-1:0] M_W_ADDR,
  output logic [LINE_WIDTH-1:0] M_W_DATA,
  input  logic                  M_W_READY,
  input  logic                  M_W_COMPLETE
);

  localparam int STREAK_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1'b1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(WR_BURST_MAX);
  // Clears the byte-in-line offset of a 64-byte line.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-6){1'b1}}, 6'b000000};
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_I    = 3'd1,
    ST_RD_D    = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [STREAK_W-1:0]   wr_streak_q, wr_streak_d;
  logic                  last_rd_q, last_rd_d;
  logic                  mask_i_q, mask_i_d;
  logic                  mask_d_q, mask_d_d;
  logic [ADDR_WIDTH-1:0] m_r_addr_q, m_r_addr_d;
  logic [ADDR_WIDTH-1:0] m_w_addr_q, m_w_addr_d;
  logic [LINE_WIDTH-1:0] m_w_data_q, m_w_data_d;

  logic rd_i_cand_s, rd_d_cand_s, rd_cand_s, wr_wins_s, pick_i_s, grant_wr_s;

  // Arbitration candidates: a port that just completed sits out one IDLE cycle.
  always_comb begin
    rd_i_cand_s = I_R_ADDR_VALID && !mask_i_q;
    rd_d_cand_s = D_R_ADDR_VALID && !mask_d_q;
    rd_cand_s   = rd_i_cand_s || rd_d_cand_s;
    // Writes win until a full burst has gone by with a read waiting.
    wr_wins_s   = D_W_VALID && !((wr_streak_q == STREAK_MAX) && rd_cand_s);
    // On a read tie, the port that was not served last goes first.
    pick_i_s    = rd_i_cand_s && (!rd_d_cand_s || (last_rd_q == LAST_D));
  end

  // Next-state logic for the transaction FSM and its captured request fields.
  always_comb begin
    state_d     = state_q;
    wr_streak_d = wr_streak_q;
    last_rd_d   = last_rd_q;
    mask_i_d    = 1'b0;
    mask_d_d    = 1'b0;
    m_r_addr_d  = m_r_addr_q;
    m_w_addr_d  = m_w_addr_q;
    m_w_data_d  = m_w_data_q;
    grant_wr_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_wins_s) begin
          grant_wr_s = 1'b1;
          state_d    = ST_WR_REQ;
          m_w_addr_d = D_W_ADDR;
          m_w_data_d = D_W_DATA;
          if (wr_streak_q != STREAK_MAX) begin
            wr_streak_d = wr_streak_q + STREAK_ONE;
          end else begin
            wr_streak_d = wr_streak_q;
          end
        end else if (pick_i_s) begin
          state_d     = ST_RD_I;
          m_r_addr_d  = I_R_ADDR & LINE_MASK;
          last_rd_d   = LAST_I;
          wr_streak_d = '0;
        end else if (rd_d_cand_s) begin
          state_d     = ST_RD_D;
          m_r_addr_d  = D_R_ADDR & LINE_MASK;
          last_rd_d   = LAST_D;
          wr_streak_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_I: begin
        if (M_R_DATA_VALID) begin
          state_d  = ST_IDLE;
          mask_i_d = 1'b1;
        end else begin
          state_d = ST_RD_I;
        end
      end
      ST_RD_D: begin
        if (M_R_DATA_VALID) begin
          state_d  = ST_IDLE;
          mask_d_d = 1'b1;
        end else begin
          state_d = ST_RD_D;
        end
      end
      ST_WR_REQ: begin
        // Accept and commit in one cycle skips the wait state entirely.
        if (M_W_READY && M_W_COMPLETE) begin
          state_d = ST_IDLE;
        end else if (M_W_READY) begin
          state_d = ST_WR_WAIT;
        end else begin
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_WAIT: begin
        if (M_W_COMPLETE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_streak_q <= '0;
      last_rd_q   <= LAST_D;
      mask_i_q    <= 1'b0;
      mask_d_q    <= 1'b0;
      m_r_addr_q  <= '0;
      m_w_addr_q  <= '0;
      m_w_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_streak_q <= wr_streak_d;
      last_rd_q   <= last_rd_d;
      mask_i_q    <= mask_i_d;
      mask_d_q    <= mask_d_d;
      m_r_addr_q  <= m_r_addr_d;
      m_w_addr_q  <= m_w_addr_d;
      m_w_data_q  <= m_w_data_d;
    end
  end

  // Response data is broadcast; only the valids select the destination.
  assign I_R_DATA       = M_R_DATA;
  assign D_R_DATA       = M_R_DATA;
  assign I_R_DATA_VALID = (state_q == ST_RD_I) && M_R_DATA_VALID;
  assign D_R_DATA_VALID = (state_q == ST_RD_D) && M_R_DATA_VALID;
  assign M_R_ADDR_VALID = (state_q == ST_RD_I) || (state_q == ST_RD_D);
  assign M_R_ADDR       = m_r_addr_q;
  assign M_W_VALID      = (state_q == ST_WR_REQ);
  assign M_W_ADDR       = m_w_addr_q;
  assign M_W_DATA       = m_w_data_q;
  assign D_W_READY      = grant_wr_s;
  assign D_W_COMPLETE   = ((state_q == ST_WR_WAIT) && M_W_COMPLETE) ||
                          ((state_q == ST_WR_REQ) && M_W_READY && M_W_COMPLETE);

endmodule

// File: tb/tb_llc_port_arbiter.sv
// Scoreboard bench for llc_port_arbiter: stimulus pushes expected LLC/L1
// events and per-cycle expectations; a single monitor pops and compares.
module tb_llc_port_arbiter;
  localparam int AW = 64;
  localparam int LW = 512;

  localparam int EV_RREQ = 0, EV_WREQ = 1, EV_IRSP = 2, EV_DRSP = 3, EV_WCMP = 4;
  localparam int S_MRV = 0, S_MRA = 1, S_IRV = 2, S_DRV = 3, S_DWR = 4,
                 S_MWV = 5, S_MWA = 6, S_MWD = 7, S_DWC = 8, S_PEND = 9;

  typedef struct { int kind; logic [AW-1:0] addr; logic [LW-1:0] data; } ev_t;
  typedef struct { int cyc; int sig; logic [LW-1:0] val; } tc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] I_R_ADDR = '0;  logic I_R_ADDR_VALID = 1'b0;
  logic [LW-1:0] I_R_DATA;       logic I_R_DATA_VALID;
  logic [AW-1:0] D_R_ADDR = '0;  logic D_R_ADDR_VALID = 1'b0;
  logic [LW-1:0] D_R_DATA;       logic D_R_DATA_VALID;
  logic D_W_VALID = 1'b0; logic [AW-1:0] D_W_ADDR = '0; logic [LW-1:0] D_W_DATA = '0;
  logic D_W_READY, D_W_COMPLETE;
  logic [AW-1:0] M_R_ADDR; logic M_R_ADDR_VALID;
  logic [LW-1:0] M_R_DATA = '0; logic M_R_DATA_VALID = 1'b0;
  logic M_W_VALID; logic [AW-1:0] M_W_ADDR; logic [LW-1:0] M_W_DATA;
  logic M_W_READY = 1'b0, M_W_COMPLETE = 1'b0;

  llc_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .WR_BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .I_R_ADDR(I_R_ADDR), .I_R_ADDR_VALID(I_R_ADDR_VALID),
    .I_R_DATA(I_R_DATA), .I_R_DATA_VALID(I_R_DATA_VALID),
    .D_R_ADDR(D_R_ADDR), .D_R_ADDR_VALID(D_R_ADDR_VALID),
    .D_R_DATA(D_R_DATA), .D_R_DATA_VALID(D_R_DATA_VALID),
    .D_W_VALID(D_W_VALID), .D_W_ADDR(D_W_ADDR), .D_W_DATA(D_W_DATA),
    .D_W_READY(D_W_READY), .D_W_COMPLETE(D_W_COMPLETE),
    .M_R_ADDR(M_R_ADDR), .M_R_ADDR_VALID(M_R_ADDR_VALID),
    .M_R_DATA(M_R_DATA), .M_R_DATA_VALID(M_R_DATA_VALID),
    .M_W_VALID(M_W_VALID), .M_W_ADDR(M_W_ADDR), .M_W_DATA(M_W_DATA),
    .M_W_READY(M_W_READY), .M_W_COMPLETE(M_W_COMPLETE)
  );

  ev_t evq[$];
  tc_t tq[$];
  logic [AW-1:0] iq[$];
  logic [AW-1:0] dq[$];
  ev_t wq[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] line_of(logic [AW-1:0] a);
    return {8{a}};
  endfunction

  function automatic logic [LW-1:0] wdata(int i);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic string sname(int s);
    case (s)
      S_MRV: return "M_R_ADDR_VALID";  S_MRA: return "M_R_ADDR";
      S_IRV: return "I_R_DATA_VALID";  S_DRV: return "D_R_DATA_VALID";
      S_DWR: return "D_W_READY";       S_MWV: return "M_W_VALID";
      S_MWA: return "M_W_ADDR";        S_MWD: return "M_W_DATA";
      S_DWC: return "D_W_COMPLETE";    default: return "pending_events";
    endcase
  endfunction

  function automatic logic [LW-1:0] sval(int s);
    case (s)
      S_MRV: return LW'(M_R_ADDR_VALID);  S_MRA: return LW'(M_R_ADDR);
      S_IRV: return LW'(I_R_DATA_VALID);  S_DRV: return LW'(D_R_DATA_VALID);
      S_DWR: return LW'(D_W_READY);       S_MWV: return LW'(M_W_VALID);
      S_MWA: return LW'(M_W_ADDR);        S_MWD: return M_W_DATA;
      S_DWC: return LW'(D_W_COMPLETE);    default: return LW'(evq.size());
    endcase
  endfunction

  function automatic string kname(int k);
    case (k)
      EV_RREQ: return "llc_read_req";  EV_WREQ: return "llc_write_req";
      EV_IRSP: return "i_read_resp";   EV_DRSP: return "d_read_resp";
      default: return "write_complete";
    endcase
  endfunction

  // ---------------- monitor / scoreboard (sole owner of the counters) -------
  task automatic check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic got_ev(int kind, logic [AW-1:0] addr, logic [LW-1:0] data);
    ev_t e;
    if (evq.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_%s @cyc %0d: got event, expected none", kname(kind), cyc);
    end else begin
      e = evq.pop_front();
      check("event_order", LW'(kind), LW'(e.kind));
      if (kind == e.kind) begin
        if (kind == EV_RREQ || kind == EV_WREQ) check({kname(kind), "_addr"}, LW'(addr), LW'(e.addr));
        if (kind != EV_RREQ) check({kname(kind), "_data"}, data, e.data);
      end
    end
  endtask

  logic prev_mrv = 1'b0;
  logic prev_mwv = 1'b0;
  always @(negedge clk) begin
    for (int i = tq.size() - 1; i >= 0; i--) begin
      if (tq[i].cyc == cyc) begin
        check(sname(tq[i].sig), sval(tq[i].sig), tq[i].val);
        tq.delete(i);
      end
    end
    if (!reset) begin
      if (M_R_ADDR_VALID && !prev_mrv) got_ev(EV_RREQ, M_R_ADDR, '0);
      if (M_W_VALID && !prev_mwv)      got_ev(EV_WREQ, M_W_ADDR, M_W_DATA);
      if (I_R_DATA_VALID)              got_ev(EV_IRSP, '0, I_R_DATA);
      if (D_R_DATA_VALID)              got_ev(EV_DRSP, '0, D_R_DATA);
      if (D_W_COMPLETE)                got_ev(EV_WCMP, '0, LW'(M_W_COMPLETE));
    end
    prev_mrv = M_R_ADDR_VALID;
    prev_mwv = M_W_VALID;
  end

  // ---------------- L1 requester models ------------------------------------
  logic i_done, d_done, w_acc;
  initial forever begin
    @(negedge clk); i_done = I_R_DATA_VALID;
    @(posedge clk); #2;
    if (reset) I_R_ADDR_VALID = 1'b0;
    else begin
      if (i_done) I_R_ADDR_VALID = 1'b0;
      if (!I_R_ADDR_VALID && iq.size() != 0) begin
        I_R_ADDR = iq.pop_front(); I_R_ADDR_VALID = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk); d_done = D_R_DATA_VALID;
    @(posedge clk); #2;
    if (reset) D_R_ADDR_VALID = 1'b0;
    else begin
      if (d_done) D_R_ADDR_VALID = 1'b0;
      if (!D_R_ADDR_VALID && dq.size() != 0) begin
        D_R_ADDR = dq.pop_front(); D_R_ADDR_VALID = 1'b1;
      end
    end
  end

  initial forever begin
    ev_t w;
    @(negedge clk); w_acc = D_W_VALID && D_W_READY;
    @(posedge clk); #2;
    if (reset) D_W_VALID = 1'b0;
    else begin
      if (w_acc) D_W_VALID = 1'b0;
      if (!D_W_VALID && wq.size() != 0) begin
        w = wq.pop_front();
        D_W_ADDR = w.addr; D_W_DATA = w.data; D_W_VALID = 1'b1;
      end
    end
  end

  // ---------------- LLC responder model -------------------------------------
  int rd_lat = 2, wr_rdy_lat = 1, wr_cmp_lat = 1;
  logic llc_en = 1'b1, stray_rd = 1'b0, stray_wc = 1'b0;
  int rd_cnt = 0, w_cnt = 0;
  logic w_pend = 1'b0;
  initial forever begin
    @(posedge clk); #2;
    M_R_DATA_VALID = stray_rd; M_W_READY = 1'b0; M_W_COMPLETE = stray_wc;
    if (stray_rd) M_R_DATA = {64{8'h5A}};
    if (!llc_en || reset) begin
      rd_cnt = 0; w_cnt = 0; w_pend = 1'b0;
    end else begin
      if (M_R_ADDR_VALID) begin
        rd_cnt++;
        if (rd_cnt >= rd_lat) begin
          M_R_DATA_VALID = 1'b1; M_R_DATA = line_of(M_R_ADDR); rd_cnt = 0;
        end
      end else rd_cnt = 0;
      if (w_pend) begin
        w_cnt++;
        if (w_cnt >= wr_cmp_lat) begin M_W_COMPLETE = 1'b1; w_pend = 1'b0; w_cnt = 0; end
      end else if (M_W_VALID) begin
        w_cnt++;
        if (w_cnt >= wr_rdy_lat) begin
          M_W_READY = 1'b1; w_cnt = 0;
          if (wr_cmp_lat == 0) M_W_COMPLETE = 1'b1; else w_pend = 1'b1;
        end
      end else w_cnt = 0;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step(); @(posedge clk); #1; endtask

  task automatic push_ev(int kind, logic [AW-1:0] addr, logic [LW-1:0] data);
    ev_t e; e.kind = kind; e.addr = addr; e.data = data; evq.push_back(e);
  endtask

  task automatic push_tc(int c, int sig, logic [LW-1:0] val);
    tc_t t; t.cyc = c; t.sig = sig; t.val = val; tq.push_back(t);
  endtask

  task automatic push_wr(logic [AW-1:0] a, logic [LW-1:0] d);
    ev_t e; e.kind = EV_WREQ; e.addr = a; e.data = d; wq.push_back(e);
  endtask

  task automatic push_zero(int c);
    for (int s = S_MRV; s <= S_DWC; s++) push_tc(c, s, '0);
  endtask

  task automatic do_reset();
    iq.delete(); dq.delete(); wq.delete();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((evq.size() != 0 || tq.size() != 0) && n < 400) begin step(); n++; end
    push_tc(cyc, S_PEND, '0);
    step(); step();
    evq.delete(); tq.delete();
  endtask

  initial begin
    int c0;
    step(); step(); reset = 1'b0;
    push_zero(cyc);                       // reset state
    step();

    // Single I read: addr aligned, valid cycles 1..6, response at cycle 6.
    rd_lat = 6; c0 = cyc;
    iq.push_back(64'h1003C);
    push_ev(EV_RREQ, 64'h10000, '0); push_ev(EV_IRSP, '0, line_of(64'h10000));
    push_tc(c0 + 1, S_MRA, LW'(64'h10000));
    for (int k = 0; k < 8; k++) begin
      push_tc(c0 + k, S_MRV, LW'((k >= 1 && k <= 6) ? 1'b1 : 1'b0));
      push_tc(c0 + k, S_IRV, LW'((k == 6) ? 1'b1 : 1'b0));
      push_tc(c0 + k, S_DRV, '0);
    end
    wait_quiet();

    // I-only back-to-back: masked in first post-completion IDLE cycle.
    do_reset(); rd_lat = 2; c0 = cyc;
    iq.push_back(64'h100); iq.push_back(64'h140);
    push_ev(EV_RREQ, 64'h100, '0); push_ev(EV_IRSP, '0, line_of(64'h100));
    push_ev(EV_RREQ, 64'h140, '0); push_ev(EV_IRSP, '0, line_of(64'h140));
    push_tc(c0 + 3, S_MRV, '0); push_tc(c0 + 4, S_MRV, '0); push_tc(c0 + 5, S_MRV, LW'(1'b1));
    wait_quiet();

    // Read fairness: I, D, I, D.
    do_reset(); rd_lat = 3;
    iq.push_back(64'h1000); iq.push_back(64'h1040);
    dq.push_back(64'h2000); dq.push_back(64'h2040);
    push_ev(EV_RREQ, 64'h1000, '0); push_ev(EV_IRSP, '0, line_of(64'h1000));
    push_ev(EV_RREQ, 64'h2000, '0); push_ev(EV_DRSP, '0, line_of(64'h2000));
    push_ev(EV_RREQ, 64'h1040, '0); push_ev(EV_IRSP, '0, line_of(64'h1040));
    push_ev(EV_RREQ, 64'h2040, '0); push_ev(EV_DRSP, '0, line_of(64'h2040));
    wait_quiet();

    // Write priority over a simultaneous D read.
    do_reset(); wr_rdy_lat = 1; wr_cmp_lat = 2; rd_lat = 2; c0 = cyc;
    push_wr(64'h2000, wdata(100)); dq.push_back(64'h3000);
    push_tc(c0, S_DWR, LW'(1'b1)); push_tc(c0, S_MWV, '0); push_tc(c0 + 1, S_MWV, LW'(1'b1));
    push_ev(EV_WREQ, 64'h2000, wdata(100)); push_ev(EV_WCMP, '0, LW'(1'b1));
    push_ev(EV_RREQ, 64'h3000, '0); push_ev(EV_DRSP, '0, line_of(64'h3000));
    wait_quiet();

    // Anti-starvation: 4 writes, then the I read, then writes resume.
    do_reset(); wr_rdy_lat = 1; wr_cmp_lat = 1; rd_lat = 2;
    for (int i = 0; i < 6; i++) push_wr(64'h8000 + 64'(i * 64), wdata(i));
    iq.push_back(64'h4000);
    for (int i = 0; i < 4; i++) begin
      push_ev(EV_WREQ, 64'h8000 + 64'(i * 64), wdata(i)); push_ev(EV_WCMP, '0, LW'(1'b1));
    end
    push_ev(EV_RREQ, 64'h4000, '0); push_ev(EV_IRSP, '0, line_of(64'h4000));
    for (int i = 4; i < 6; i++) begin
      push_ev(EV_WREQ, 64'h8000 + 64'(i * 64), wdata(i)); push_ev(EV_WCMP, '0, LW'(1'b1));
    end
    wait_quiet();

    // Stall stability: ready low for 3 cycles.
    do_reset(); wr_rdy_lat = 4; wr_cmp_lat = 1; c0 = cyc;
    push_wr(64'h5040, wdata(7));
    push_ev(EV_WREQ, 64'h5040, wdata(7)); push_ev(EV_WCMP, '0, LW'(1'b1));
    for (int k = 1; k <= 4; k++) begin
      push_tc(c0 + k, S_MWV, LW'(1'b1)); push_tc(c0 + k, S_MWA, LW'(64'h5040));
      push_tc(c0 + k, S_MWD, wdata(7));  push_tc(c0 + k, S_DWC, '0);
    end
    push_tc(c0 + 5, S_DWC, LW'(1'b1));
    wait_quiet();

    // Ready and complete in the same cycle: commit straight back to IDLE.
    do_reset(); wr_rdy_lat = 2; wr_cmp_lat = 0;
    push_wr(64'h6000, wdata(8)); push_wr(64'h6040, wdata(9));
    push_ev(EV_WREQ, 64'h6000, wdata(8)); push_ev(EV_WCMP, '0, LW'(1'b1));
    push_ev(EV_WREQ, 64'h6040, wdata(9)); push_ev(EV_WCMP, '0, LW'(1'b1));
    wait_quiet();

    // Reset mid-read, stray responses afterwards, then a normal read.
    do_reset(); rd_lat = 20; c0 = cyc;
    dq.push_back(64'h6000);
    push_ev(EV_RREQ, 64'h6000, '0);
    push_tc(c0 + 1, S_MRV, LW'(1'b1));
    step(); step(); step(); step();
    reset = 1'b1; llc_en = 1'b0; dq.delete();
    step();
    reset = 1'b0; stray_rd = 1'b1; stray_wc = 1'b1;
    push_zero(cyc);
    step();
    stray_rd = 1'b0; stray_wc = 1'b0; llc_en = 1'b1; rd_lat = 3;
    dq.push_back(64'h7000);
    push_ev(EV_RREQ, 64'h7000, '0); push_ev(EV_DRSP, '0, line_of(64'h7000));
    push_tc(cyc + 1, S_MRV, LW'(1'b1));
    wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end
endmodule
